// File: rtl/sign_narrow.sv
// sign_narrow: narrows signed 16-bit words to signed 8-bit results.
// Each accepted word passes through a 2-entry FIFO with valid/ready
// handshakes on both sides. The block flags words that do not fit in
// 8 bits and keeps overflow statistics.
//
// Ports:
//   clk         single clock, rising edge
//   rst         synchronous active-high reset
//   in_valid    in_data is offered
//   in_ready    a word can be accepted this cycle (registered)
//   in_data     signed 16-bit input word
//   out_valid   out_data/out_ovf hold a result
//   out_ready   consumer takes the result this cycle
//   out_data    narrowed signed 8-bit result
//   out_ovf     result is not range-exact
//   clr_ovf     clears ovf_sticky and ovf_count
//   ovf_sticky  an overflowing word was accepted since reset/clear
//   ovf_count   number of overflowing words accepted, saturating
//
// Build option: define SIGN_NARROW_SAT_EN to saturate overflowing words
// to 0x7F/0x80. Without it, overflowing words are truncated to in_data[7:0].
module sign_narrow #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             out_ovf,
    input  logic             clr_ovf,
    output logic             ovf_sticky,
    output logic [CNT_W-1:0] ovf_count
);

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    occ_e             occ_q, occ_d;
    logic             rdy_q, rdy_d;
    logic [7:0]       head_data_q, head_data_d;
    logic             head_ovf_q, head_ovf_d;
    logic [7:0]       tail_data_q, tail_data_d;
    logic             tail_ovf_q, tail_ovf_d;
    logic             sticky_q, sticky_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             push, pop;
    logic             in_ovf;
    logic [7:0]       in_narrow;

    // Narrowing: the word fits when the upper byte is the sign extension of bit 7.
    always_comb begin
        in_ovf = (in_data[15:8] != {8{in_data[7]}});
`ifdef SIGN_NARROW_SAT_EN
        if (in_ovf) begin
            in_narrow = in_data[15] ? 8'h80 : 8'h7F;
        end else begin
            in_narrow = in_data[7:0];
        end
`else
        in_narrow = in_data[7:0];
`endif
    end

    assign push = in_valid && rdy_q;
    assign pop  = (occ_q != OCC_EMPTY) && out_ready;

    // The head entry drives the outputs directly; the tail entry only holds
    // the second word while the consumer stalls.
    always_comb begin
        occ_d       = occ_q;
        head_data_d = head_data_q;
        head_ovf_d  = head_ovf_q;
        tail_data_d = tail_data_q;
        tail_ovf_d  = tail_ovf_q;
        unique case (occ_q)
            OCC_EMPTY: begin
                if (push) begin
                    head_data_d = in_narrow;
                    head_ovf_d  = in_ovf;
                    occ_d       = OCC_ONE;
                end
            end
            OCC_ONE: begin
                if (push && pop) begin
                    head_data_d = in_narrow;
                    head_ovf_d  = in_ovf;
                end else if (push) begin
                    tail_data_d = in_narrow;
                    tail_ovf_d  = in_ovf;
                    occ_d       = OCC_FULL;
                end else if (pop) begin
                    occ_d = OCC_EMPTY;
                end
            end
            OCC_FULL: begin
                // in_ready is low while full, so no push can coincide here.
                if (pop) begin
                    head_data_d = tail_data_q;
                    head_ovf_d  = tail_ovf_q;
                    occ_d       = OCC_ONE;
                end
            end
            default: begin
                occ_d = OCC_EMPTY;
            end
        endcase
        // Registered ready: a slot freed by a pop becomes visible next cycle.
        rdy_d = (occ_d != OCC_FULL);
    end

    // Overflow statistics; an overflow accepted alongside a clear survives it.
    always_comb begin
        sticky_d = sticky_q;
        cnt_d    = cnt_q;
        if (clr_ovf) begin
            sticky_d = push && in_ovf;
            cnt_d    = (push && in_ovf) ? CNT_W'(1) : '0;
        end else if (push && in_ovf) begin
            sticky_d = 1'b1;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q       <= OCC_EMPTY;
            rdy_q       <= 1'b0;
            head_data_q <= '0;
            head_ovf_q  <= 1'b0;
            tail_data_q <= '0;
            tail_ovf_q  <= 1'b0;
            sticky_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            occ_q       <= occ_d;
            rdy_q       <= rdy_d;
            head_data_q <= head_data_d;
            head_ovf_q  <= head_ovf_d;
            tail_data_q <= tail_data_d;
            tail_ovf_q  <= tail_ovf_d;
            sticky_q    <= sticky_d;
            cnt_q       <= cnt_d;
        end
    end

    assign in_ready   = rdy_q;
    assign out_valid  = (occ_q != OCC_EMPTY);
    assign out_data   = head_data_q;
    assign out_ovf    = head_ovf_q;
    assign ovf_sticky = sticky_q;
    assign ovf_count  = cnt_q;

endmodule

// File: tb/tb_sign_narrow.sv
// Testbench for sign_narrow: directed scenarios plus randomized traffic.
// Expected results come from an arithmetic range model and are queued at
// acceptance; a separate monitor compares them as the DUT presents output.
module tb_sign_narrow;

    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_data;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_data;
    logic             out_ovf;
    logic             clr_ovf;
    logic             ovf_sticky;
    logic [CNT_W-1:0] ovf_count;

    sign_narrow #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_ovf    (out_ovf),
        .clr_ovf    (clr_ovf),
        .ovf_sticky (ovf_sticky),
        .ovf_count  (ovf_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic       o;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state (protocol-level view of the block).
    int   m_occ    = 0;
    bit   m_rstd   = 1'b1;   // previous edge was a reset edge
    int   m_cnt    = 0;
    bit   m_sticky = 1'b0;

    // Range-based reference: a word overflows when its signed value lies
    // outside -128..127.
    function automatic exp_t model(input logic [15:0] w);
        int   v;
        exp_t e;
        v   = int'($signed(w));
        e.o = (v > 127) || (v < -128);
        e.d = w[7:0];
`ifdef SIGN_NARROW_SAT_EN
        if (e.o) e.d = (v > 0) ? 8'h7F : 8'h80;
`endif
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Acceptance recorder and status checker: checks the state left by the
    // previous edge, then advances the model with this cycle's inputs.
    always @(negedge clk) begin
        bit   acc;
        bit   pop;
        exp_t e;
        chk("in_ready",   int'(in_ready),   int'(!m_rstd && m_occ < 2));
        chk("out_valid",  int'(out_valid),  int'(m_occ > 0));
        chk("ovf_count",  int'(ovf_count),  m_cnt);
        chk("ovf_sticky", int'(ovf_sticky), int'(m_sticky));
        if (m_rstd) begin
            chk("rst_out_data", int'(out_data), 0);
            chk("rst_out_ovf",  int'(out_ovf),  0);
        end
        if (rst) begin
            m_occ    = 0;
            m_cnt    = 0;
            m_sticky = 1'b0;
            m_rstd   = 1'b1;
            sb.delete();
        end else begin
            acc = in_valid && !m_rstd && (m_occ < 2);
            pop = (m_occ > 0) && out_ready;
            e   = model(in_data);
            if (acc) sb.push_back(e);
            if (clr_ovf) begin
                m_sticky = acc && e.o;
                m_cnt    = (acc && e.o) ? 1 : 0;
            end else if (acc && e.o) begin
                m_sticky = 1'b1;
                if (m_cnt < CNT_MAX) m_cnt++;
            end
            m_occ  = m_occ + int'(acc) - int'(pop);
            m_rstd = 1'b0;
        end
    end

    // Output monitor: every presented result must match the queue head,
    // including while it is held by a stalled consumer.
    always @(negedge clk) begin
        if (!rst && out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got data 0x%0h ovf %0b, expected none at %0t",
                         out_data, out_ovf, $time);
            end else begin
                chk("out_data", int'(out_data), int'(sb[0].d));
                chk("out_ovf",  int'(out_ovf),  int'(sb[0].o));
                if (out_ready) void'(sb.pop_front());
            end
        end
    end

    task automatic drive(input logic v, input logic [15:0] d, input logic ordy,
                         input logic clr, input logic r);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        clr_ovf   = clr;
        rst       = r;
        @(posedge clk);
        #1;
    endtask

    // Offer a word until it is accepted, bounded to 50 cycles.
    task automatic send(input logic [15:0] d, input logic ordy, input logic clr);
        bit acc;
        acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) begin
            in_valid  = 1'b1;
            in_data   = d;
            out_ready = ordy;
            clr_ovf   = clr;
            rst       = 1'b0;
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        clr_ovf  = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no acceptance, expected one within 50 cycles for 0x%0h", d);
        end
    endtask

    function automatic logic [15:0] rand_word();
        logic [15:0] edges [8];
        logic [7:0]  b;
        edges[0] = 16'h007F; edges[1] = 16'h0080; edges[2] = 16'hFF80; edges[3] = 16'hFF7F;
        edges[4] = 16'h7FFF; edges[5] = 16'h8000; edges[6] = 16'hFFFF; edges[7] = 16'h0000;
        case ($urandom_range(0, 3))
            0: begin
                b = 8'($urandom);
                return {{8{b[7]}}, b};
            end
            1: return edges[$urandom_range(0, 7)];
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        clr_ovf   = 1'b0;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        drive(1'b1, 16'h1234, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);

        // In-range negative word, latency 1.
        send(16'hFF85, 1'b1, 1'b0);
        chk("d_ff85_data", int'(out_data), 8'h85);
        chk("d_ff85_ovf",  int'(out_ovf),  0);
        chk("d_ff85_cnt",  int'(ovf_count), 0);

        // Positive and negative overflow.
        send(16'h0123, 1'b1, 1'b0);
`ifdef SIGN_NARROW_SAT_EN
        chk("d_0123_data", int'(out_data), 8'h7F);
`else
        chk("d_0123_data", int'(out_data), 8'h23);
`endif
        chk("d_0123_ovf", int'(out_ovf),    1);
        chk("d_0123_stk", int'(ovf_sticky), 1);
        chk("d_0123_cnt", int'(ovf_count),  1);
        send(16'h8000, 1'b1, 1'b0);
`ifdef SIGN_NARROW_SAT_EN
        chk("d_8000_data", int'(out_data), 8'h80);
`else
        chk("d_8000_data", int'(out_data), 8'h00);
`endif
        drive(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);

        // Backpressure: two fill the FIFO, the third waits.
        send(16'h0001, 1'b0, 1'b0);
        send(16'h0002, 1'b0, 1'b0);
        drive(1'b1, 16'h0003, 1'b0, 1'b0, 1'b0);
        chk("bp_in_ready", int'(in_ready), 0);
        chk("bp_hold",     int'(out_data), 8'h01);
        send(16'h0003, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);

        // Counter saturation and clear coinciding with an overflow.
        for (int i = 0; i < 300; i++) send(16'h4000, 1'b1, 1'b0);
        chk("sat_cnt", int'(ovf_count), CNT_MAX);
        send(16'h4000, 1'b1, 1'b1);
        chk("clr_cnt", int'(ovf_count),  1);
        chk("clr_stk", int'(ovf_sticky), 1);
        drive(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);

        // Reset with a full FIFO and a word on offer.
        send(16'h0011, 1'b0, 1'b0);
        send(16'h0022, 1'b0, 1'b0);
        drive(1'b1, 16'h0055, 1'b0, 1'b0, 1'b1);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_cnt",   int'(ovf_count), 0);
        drive(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        chk("rst_ready", int'(in_ready), 1);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            drive(1'($urandom_range(0, 3) != 0), rand_word(),
                  1'($urandom_range(0, 4) < 3),
                  1'($urandom_range(0, 24) == 0),
                  1'($urandom_range(0, 149) == 0));
        end

        // Drain and confirm every accepted word came out.
        for (int i = 0; i < 10; i++) drive(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        chk("drain_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sign_narrow.md
SIGN_NARROW -- requirements
Module: sign_narrow

Interface
REQ-001 Parameter CNT_W, default 8, is the width of the overflow event counter.
REQ-002 clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  is the synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 in_valid  input  1  SHALL indicate that in_data is offered.
REQ-005 in_ready  output  1  SHALL indicate that the block can accept in_data this cycle.
REQ-006 in_data  input  16  is the signed two's-complement word to be narrowed.
REQ-007 out_valid  output  1  SHALL indicate that out_data and out_ovf hold a result.
REQ-008 out_ready  input  1  SHALL indicate that the consumer takes the result this cycle.
REQ-009 out_data  output  8  is the narrowed signed result.
REQ-010 out_ovf  output  1  SHALL flag that the result is not range-exact for the word on out_data.
REQ-011 clr_ovf  input  1  SHALL clear the overflow statistics.
REQ-012 ovf_sticky  output  1  SHALL flag that an overflow was accepted since the last reset or clear.
REQ-013 ovf_count  output  CNT_W  SHALL give the number of overflowing words accepted, saturating at all-ones.

Function
REQ-014 A transfer SHALL occur on the input when in_valid and in_ready are both 1, and on the output when out_valid and out_ready are both 1.
REQ-015 Results SHALL be buffered in a 2-entry FIFO with occupancy 0..2; in_ready SHALL be 1 exactly when occupancy < 2, and out_valid SHALL be 1 exactly when occupancy > 0.
REQ-016 A word accepted while the FIFO is empty SHALL appear on out_valid/out_data on the next cycle, giving a latency of 1 cycle; results SHALL leave in acceptance order.
REQ-017 When the FIFO is full and an output transfer occurs, in_ready SHALL stay 0 in that cycle; the freed entry SHALL become available in the following cycle.
REQ-018 When an input transfer and an output transfer occur in the same cycle, occupancy SHALL be unchanged and no data SHALL be lost or duplicated.
REQ-019 An overflow SHALL be defined as in_data[15:8] not equal to eight copies of in_data[7].
REQ-020 A non-overflowing word SHALL produce out_data = in_data[7:0] and out_ovf = 0.
REQ-021 An overflowing word SHALL produce out_ovf = 1; its out_data SHALL be as given in REQ-030/REQ-031.
REQ-022 On each accepted overflowing word, ovf_sticky SHALL be set to 1 and ovf_count SHALL increment by 1 unless it is already all-ones, in which case it SHALL hold and SHALL NOT wrap.
REQ-023 clr_ovf = 1 SHALL set ovf_sticky to 0 and ovf_count to 0 on the next edge.
REQ-024 If an overflowing word is accepted in the same cycle as clr_ovf, the result after that edge SHALL be ovf_sticky = 1 and ovf_count = 1.
REQ-025 When out_valid is 1 and out_ready is 0, out_data and out_ovf SHALL hold stable.
REQ-026 in_ready SHALL be a function of registered state only and SHALL NOT depend combinationally on out_ready.

Reset
REQ-027 While rst = 1, the FIFO SHALL be emptied: occupancy 0, out_valid = 0, in_ready = 0.
REQ-028 Reset SHALL also force out_data = 0x00, out_ovf = 0, ovf_sticky = 0 and ovf_count = 0.
REQ-029 Reset SHALL take priority over every other input; a word offered in a reset cycle SHALL be discarded, and in_ready SHALL become 1 on the first cycle after rst is deasserted.

Configuration
REQ-030 With macro SIGN_NARROW_SAT_EN defined, an overflowing word SHALL saturate: out_data = 0x7F when in_data[15] = 0, and 0x80 when in_data[15] = 1.
REQ-031 Without SIGN_NARROW_SAT_EN, an overflowing word SHALL truncate: out_data = in_data[7:0]; out_ovf and the statistics SHALL behave identically in both builds.

Verification
REQ-032 After reset, offer in_data 0xFF85 with out_ready = 1 -> one cycle later out_data = 0x85, out_ovf = 0, ovf_count = 0.
REQ-033 Offer in_data 0x0123 -> out_ovf = 1, ovf_sticky = 1, ovf_count = 1; out_data = 0x7F with SAT_EN, 0x23 without. Offer in_data 0x8000 -> out_data = 0x80 with SAT_EN, 0x00 without.
REQ-034 With out_ready = 0, offer 0x0001, 0x0002, 0x0003 -> in_ready = 0 after two acceptances and out_data holds 0x01; then raise out_ready -> 0x01, 0x02, 0x03 emerge in order with no loss.
REQ-035 Offer 300 consecutive 0x4000 words with CNT_W = 8 -> ovf_count = 255 and holds; then assert clr_ovf together with one more 0x4000 -> ovf_count = 1, ovf_sticky = 1.
REQ-036 Fill the FIFO with 2 entries, then assert rst for one cycle while in_valid = 1 -> out_valid = 0, ovf_count = 0, the offered word is not delivered, and in_ready = 1 on the next cycle.
